// File: rtl/ram_wait_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_wait_responder_pkg
// Description : Shared bus-width defines, FSM state type and wait-counter width
//               for the wait-state RAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif
`ifndef MEM_SEL_BUS
`define MEM_SEL_BUS 3:0
`endif

package ram_wait_responder_pkg;
    localparam int c_WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;
endpackage
`default_nettype wire

// File: rtl/ram_wait_responder_sram_bytelane.sv
`default_nettype none
// ============================================================================
// Module      : sram_bytelane
// Description : Single-port 32-bit array, synchronous read, per-byte write.
//               Only the read register is reset; array contents are not.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_bytelane #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_en,
    input  logic [`MEM_SEL_BUS] i_we,
    input  logic [IDX_W-1:0]    i_addr,
    input  logic [`DATA_BUS]    i_wdata,
    output logic [`DATA_BUS]    o_rdata
);
    logic [3:0][7:0] r_mem [DEPTH_WORDS];
    logic [31:0]     r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int i = 0; i < 4; i++) begin
                if (i_we[i]) begin
                    r_mem[i_addr][i] <= i_wdata[i*8 +: 8];
                end
            end
        end
    end

    // Read register only moves on reads, so writes leave it untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (i_en && (i_we == '0)) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;
endmodule
`default_nettype wire

// File: rtl/ram_wait_responder.sv
`default_nettype none
// ============================================================================
// Module      : ram_wait_responder
// Description : Core-facing RAM with WAIT_CYCLES stall cycles per access and a
//               sticky out-of-range flag. Optional counters: RAM_RESP_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_wait_responder
    import ram_wait_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ram_en,
    input  logic [`MEM_SEL_BUS] ram_write_en,
    input  logic [`ADDR_BUS]    ram_addr,
    input  logic [`DATA_BUS]    ram_write_data,
    output logic [`DATA_BUS]    ram_read_data,
    output logic                stall,
    output logic                addr_err
`ifdef RAM_RESP_STATS_EN
    ,
    output logic [31:0]         stat_reads,
    output logic [31:0]         stat_writes,
    output logic [31:0]         stat_stall_cycles
`endif
);
    localparam int c_IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [c_WAIT_CNT_W-1:0] c_WAIT_LOAD =
        (WAIT_CYCLES > 0) ? c_WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

    state_t                  r_state, w_state_nxt;
    logic [c_WAIT_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [31:0]             r_addr, r_wdata;
    logic [3:0]              r_we;
    logic                    r_addr_err, r_oor_rd;

    logic        w_accept, w_fire, w_acc_oor, w_acc_rd, w_mem_en, w_rd_done;
    logic [31:0] w_acc_addr, w_acc_wdata, w_mem_rdata;
    logic [3:0]  w_acc_we;
    logic        w_unused;

    assign w_accept = (r_state != ST_WAIT) && ram_en;

    generate
        if (WAIT_CYCLES == 0) begin : g_direct
            assign w_fire      = w_accept;
            assign w_acc_addr  = ram_addr;
            assign w_acc_we    = ram_write_en;
            assign w_acc_wdata = ram_write_data;
        end else begin : g_latched
            assign w_fire      = (r_state == ST_WAIT) && (r_cnt == '0);
            assign w_acc_addr  = r_addr;
            assign w_acc_we    = r_we;
            assign w_acc_wdata = r_wdata;
        end
    endgenerate

    assign w_acc_oor = |w_acc_addr[31:c_IDX_W+2];
    assign w_acc_rd  = (w_acc_we == '0);
    assign w_mem_en  = w_fire && !w_acc_oor;
    assign w_rd_done = w_fire && w_acc_rd;
    assign w_unused  = ^w_acc_addr[1:0];

    // The final WAIT cycle (counter at zero) releases the core while the access completes.
    assign stall = rst && (WAIT_CYCLES != 0) &&
                   (w_accept || ((r_state == ST_WAIT) && (r_cnt != '0)));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                if (!ram_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (WAIT_CYCLES == 0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = c_WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_we    <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_addr  <= ram_addr;
            r_we    <= ram_write_en;
            r_wdata <= ram_write_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr_err <= 1'b0;
            r_oor_rd   <= 1'b0;
        end else begin
            if (w_fire && w_acc_oor) begin
                r_addr_err <= 1'b1;
            end
            if (w_rd_done) begin
                r_oor_rd <= w_acc_oor;
            end
        end
    end

    sram_bytelane #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (c_IDX_W)
    ) u_sram (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_mem_en),
        .i_we    (w_acc_we),
        .i_addr  (w_acc_addr[c_IDX_W+1:2]),
        .i_wdata (w_acc_wdata),
        .o_rdata (w_mem_rdata)
    );

    assign ram_read_data = r_oor_rd ? '0 : w_mem_rdata;
    assign addr_err      = r_addr_err;

`ifdef RAM_RESP_STATS_EN
    logic [31:0] r_stat_rd, r_stat_wr, r_stat_st;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_rd <= '0;
            r_stat_wr <= '0;
            r_stat_st <= '0;
        end else begin
            if (w_rd_done && (r_stat_rd != '1)) r_stat_rd <= r_stat_rd + 1'b1;
            if (w_fire && !w_acc_rd && (r_stat_wr != '1)) r_stat_wr <= r_stat_wr + 1'b1;
            if (stall && (r_stat_st != '1)) r_stat_st <= r_stat_st + 1'b1;
        end
    end

    assign stat_reads        = r_stat_rd;
    assign stat_writes       = r_stat_wr;
    assign stat_stall_cycles = r_stat_st;
`endif
endmodule
`default_nettype wire

// File: tb/tb_ram_wait_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_wait_responder
// Description : Scoreboard bench for ram_wait_responder (WAIT_CYCLES=2 and =0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_wait_responder;
    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ram_en = 1'b0, en0 = 1'b0;
    logic [3:0]  ram_write_en = '0, we0 = '0;
    logic [31:0] ram_addr = '0, ram_write_data = '0, addr0 = '0, wd0 = '0;
    logic [31:0] ram_read_data, rdata0;
    logic        stall, addr_err, stall0, addr_err0;
`ifdef RAM_RESP_STATS_EN
    logic [31:0] s_rd, s_wr, s_st, s0_rd, s0_wr, s0_st;
`endif

    int          total = 0;
    int          bad   = 0;
    logic [31:0] sb[$];
    logic [31:0] sb0[$];
    logic [31:0] last_exp = '0;
    logic [31:0] last0 = '0;

    always #5 clk = ~clk;

    ram_wait_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .ram_en(ram_en), .ram_write_en(ram_write_en),
        .ram_addr(ram_addr), .ram_write_data(ram_write_data),
        .ram_read_data(ram_read_data), .stall(stall), .addr_err(addr_err)
`ifdef RAM_RESP_STATS_EN
        , .stat_reads(s_rd), .stat_writes(s_wr), .stat_stall_cycles(s_st)
`endif
    );

    ram_wait_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .ram_en(en0), .ram_write_en(we0),
        .ram_addr(addr0), .ram_write_data(wd0),
        .ram_read_data(rdata0), .stall(stall0), .addr_err(addr_err0)
`ifdef RAM_RESP_STATS_EN
        , .stat_reads(s0_rd), .stat_writes(s0_wr), .stat_stall_cycles(s0_st)
`endif
    );

    // Called at a negedge in an accepting cycle T; returns at the negedge of T+W+1.
    task automatic issue(input string tag, input logic [31:0] a, input logic [3:0] we,
                         input logic [31:0] wd, input logic [31:0] exp);
        logic exp_st;
        ram_en = 1'b1; ram_addr = a; ram_write_en = we; ram_write_data = wd;
        #1;
        if (sb.size() > 0) last_exp = sb.pop_front();
        total++;
        if (ram_read_data !== last_exp) begin
            bad++;
            $display("FAIL %s rdata: got %h want %h", tag, ram_read_data, last_exp);
        end
        if (we == 4'h0) sb.push_back(exp);
        for (int k = 0; k <= W; k++) begin
            if (k > 0) begin
                @(negedge clk);
                ram_en = 1'b1; ram_addr = $urandom; ram_write_en = 4'($urandom);
                ram_write_data = $urandom;
                #1;
            end
            exp_st = (k < W);
            total++;
            if (stall !== exp_st) begin
                bad++;
                $display("FAIL %s stall[T+%0d]: got %b want %b", tag, k, stall, exp_st);
            end
        end
        @(negedge clk);
        ram_en = 1'b0;
    endtask

    task automatic drain(input string tag);
        ram_en = 1'b0;
        #1;
        if (sb.size() > 0) last_exp = sb.pop_front();
        total++;
        if (ram_read_data !== last_exp) begin
            bad++;
            $display("FAIL %s drain rdata: got %h want %h", tag, ram_read_data, last_exp);
        end
        @(negedge clk);
    endtask

    task automatic issue0(input string tag, input logic [31:0] a, input logic [3:0] we,
                          input logic [31:0] wd, input logic [31:0] exp);
        en0 = 1'b1; addr0 = a; we0 = we; wd0 = wd;
        if (we == 4'h0) sb0.push_back(exp);
        #1;
        total++;
        if (stall0 !== 1'b0) begin
            bad++;
            $display("FAIL %s stall0: got %b want 0", tag, stall0);
        end
        @(negedge clk);
        en0 = 1'b0;
        #1;
        if (sb0.size() > 0) last0 = sb0.pop_front();
        total++;
        if (rdata0 !== last0) begin
            bad++;
            $display("FAIL %s rdata0: got %h want %h", tag, rdata0, last0);
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0; ram_en = 1'b1; en0 = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL reset stall: got %b want 0", stall); end
        total++;
        if (ram_read_data !== 32'h0) begin
            bad++; $display("FAIL reset rdata: got %h want 0", ram_read_data);
        end
        total++;
        if (addr_err !== 1'b0) begin bad++; $display("FAIL reset addr_err: got %b want 0", addr_err); end
        total++;
        if (rdata0 !== 32'h0) begin bad++; $display("FAIL reset rdata0: got %h want 0", rdata0); end
        ram_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        issue("basic_w", 32'h10, 4'hF, 32'hDEADBEEF, '0);
        issue("basic_r", 32'h10, 4'h0, '0, 32'hDEADBEEF);
        drain("basic_r");
    endtask

    task automatic test_lanes;
        issue("lane_init", 32'h20, 4'hF, 32'h11223344, '0);
        issue("lane_w0101", 32'h20, 4'b0101, 32'hAABBCCDD, '0);
        issue("lane_r1", 32'h20, 4'h0, '0, 32'h11BB33DD);
        issue("lane_w1010", 32'h20, 4'b1010, 32'h55667788, '0);
        issue("lane_r2", 32'h20, 4'h0, '0, 32'h55BB77DD);
        drain("lane_r2");
    endtask

    task automatic test_back_to_back;
        issue("b2b_w0", 32'h0, 4'hF, 32'hA0A0A0A0, '0);
        issue("b2b_w1", 32'h4, 4'hF, 32'hA1A1A1A1, '0);
        issue("b2b_w2", 32'h8, 4'hF, 32'hA2A2A2A2, '0);
        issue("b2b_r0", 32'h0, 4'h0, '0, 32'hA0A0A0A0);
        issue("b2b_r1", 32'h4, 4'h0, '0, 32'hA1A1A1A1);
        issue("b2b_r2", 32'h8, 4'h0, '0, 32'hA2A2A2A2);
        issue("b2b_unal", 32'h7, 4'h0, '0, 32'hA1A1A1A1);
        drain("b2b_unal");
    endtask

    task automatic test_out_of_range;
        issue("oor_init0", 32'h0, 4'hF, 32'h01234567, '0);
        issue("oor_init1023", 32'hFFC, 4'hF, 32'h89ABCDEF, '0);
        drain("oor_init");
        total++;
        if (addr_err !== 1'b0) begin bad++; $display("FAIL oor pre addr_err: got %b want 0", addr_err); end
        issue("oor_r", 32'h1000, 4'h0, '0, 32'h0);
        drain("oor_r");
        total++;
        if (addr_err !== 1'b1) begin bad++; $display("FAIL oor addr_err: got %b want 1", addr_err); end
        issue("oor_w", 32'h1000, 4'hF, 32'hFFFFFFFF, '0);
        issue("oor_whi", 32'h80000FFC, 4'hF, 32'hFFFFFFFF, '0);
        issue("oor_chk0", 32'h0, 4'h0, '0, 32'h01234567);
        issue("oor_chk1023", 32'hFFC, 4'h0, '0, 32'h89ABCDEF);
        drain("oor_chk");
        total++;
        if (addr_err !== 1'b1) begin bad++; $display("FAIL oor sticky addr_err: got %b want 1", addr_err); end
    endtask

    task automatic test_reset_mid_write;
        issue("rmw_old", 32'h40, 4'hF, 32'h600DF00D, '0);
        ram_en = 1'b1; ram_addr = 32'h40; ram_write_en = 4'hF; ram_write_data = 32'hBADBAD00;
        @(negedge clk);
        ram_en = 1'b0;
        rst = 1'b0;
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL rmw stall: got %b want 0", stall); end
        total++;
        if (addr_err !== 1'b0) begin bad++; $display("FAIL rmw addr_err: got %b want 0", addr_err); end
        last_exp = '0;
        last0 = '0;
        sb.delete();
        sb0.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue("rmw_r", 32'h40, 4'h0, '0, 32'h600DF00D);
        drain("rmw_r");
    endtask

    task automatic test_nowait;
        issue0("nw_w", 32'h30, 4'hF, 32'hCAFEF00D, '0);
        issue0("nw_r0", 32'h30, 4'h0, '0, 32'hCAFEF00D);
        issue0("nw_r1", 32'h31, 4'h0, '0, 32'hCAFEF00D);
        issue0("nw_r2", 32'h33, 4'h0, '0, 32'hCAFEF00D);
`ifdef RAM_RESP_STATS_EN
        total++;
        if (s0_rd !== 32'd3) begin bad++; $display("FAIL stat_reads: got %0d want 3", s0_rd); end
        total++;
        if (s0_wr !== 32'd1) begin bad++; $display("FAIL stat_writes: got %0d want 1", s0_wr); end
        total++;
        if (s0_st !== 32'd0) begin bad++; $display("FAIL stat_stall_cycles: got %0d want 0", s0_st); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lanes();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_write();
        test_nowait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
